// File: rtl/ladybird_irq_controller_pkg.sv
// Shared constants, register map and state encoding for the ladybird interrupt controller.
package ladybird_config;

   localparam int unsigned IRQ_ADDR_W = 4;
   localparam int unsigned IRQ_DATA_W = 32;
   // Wide enough for a source index up to 31.
   localparam int unsigned IRQ_IDX_W  = 5;

   localparam logic [IRQ_ADDR_W-1:0] IRQ_ENABLE_ADDR    = 4'h0;
   localparam logic [IRQ_ADDR_W-1:0] IRQ_PRIO_ADDR      = 4'h1;
   localparam logic [IRQ_ADDR_W-1:0] IRQ_THRESHOLD_ADDR = 4'h2;
   localparam logic [IRQ_ADDR_W-1:0] IRQ_CLAIM_ADDR     = 4'h3;
   localparam logic [IRQ_ADDR_W-1:0] IRQ_COMPLETE_ADDR  = 4'h4;
   localparam logic [IRQ_ADDR_W-1:0] IRQ_PENDING_ADDR   = 4'h5;
   localparam logic [IRQ_ADDR_W-1:0] IRQ_EDGE_ADDR      = 4'h6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      CLAIMED = 2'd2,
      DONE    = 2'd3
   } irq_state_t;

   // Register port request payload.
   typedef struct packed {
      logic                  we;
      logic [IRQ_ADDR_W-1:0] addr;
      logic [IRQ_DATA_W-1:0] wdata;
   } irq_reg_req_t;

endpackage

// File: rtl/ladybird_irq_controller_arbiter.sv
// Combinational priority select: highest priority eligible source wins, ties to lowest index.
module ladybird_irq_arbiter
   import ladybird_config::*;
#(
   parameter int unsigned N_SRC  = 8,
   parameter int unsigned PRIO_W = 2
) (
   input  logic [N_SRC-1:0]        eligible,
   input  logic [N_SRC*PRIO_W-1:0] prio,
   output logic                    valid,
   output logic [IRQ_IDX_W-1:0]    idx
);

   logic [PRIO_W-1:0] best_prio;

   // Ascending scan with strict compare keeps the lowest index on ties.
   always_comb begin
      valid     = 1'b0;
      idx       = '0;
      best_prio = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (eligible[i] && (!valid || (prio[i*PRIO_W +: PRIO_W] > best_prio))) begin
            valid     = 1'b1;
            idx       = IRQ_IDX_W'(i);
            best_prio = prio[i*PRIO_W +: PRIO_W];
         end
      end
   end

endmodule

// File: rtl/ladybird_irq_controller.sv
// Ladybird interrupt controller: per-source enable/priority/threshold, claim/complete
// handshake to the core and one-hot completion pulse back to the peripheral.
// Optional build macro LADYBIRD_IRQ_EDGE_EN adds per-source rising-edge capture (register 0x6).
module ladybird_irq_controller
   import ladybird_config::*;
#(
   parameter int unsigned N_SRC  = 8,
   parameter int unsigned PRIO_W = 2
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [N_SRC-1:0]      src_pending,
   output logic [N_SRC-1:0]      src_complete,
   output logic                  irq,
   input  logic                  core_complete,
   input  logic                  req,
   input  logic                  we,
   input  logic [IRQ_ADDR_W-1:0] addr,
   input  logic [IRQ_DATA_W-1:0] wdata,
   output logic [IRQ_DATA_W-1:0] rdata,
   output logic                  ack
);

   localparam int unsigned PRIO_BITS = N_SRC * PRIO_W;

   irq_reg_req_t           bus_req;
   irq_state_t             state_q, state_d;
   logic [IRQ_IDX_W-1:0]   claimed_q, claimed_d;
   logic [N_SRC-1:0]       enable_q;
   logic [PRIO_BITS-1:0]   prio_q;
   logic [PRIO_W-1:0]      thresh_q;
   logic [N_SRC-1:0]       src_eff;
   logic [N_SRC-1:0]       eligible;
   logic                   win_valid;
   logic [IRQ_IDX_W-1:0]   win_idx;
   logic                   wr_en, rd_en, claim_ok, cmp_wr, completion;
   logic [IRQ_DATA_W-1:0]  rd_val;
   logic                   irq_q, ack_q;
   logic [N_SRC-1:0]       src_complete_q;
   logic [IRQ_DATA_W-1:0]  rdata_q;

   assign bus_req = '{we: we, addr: addr, wdata: wdata};

   // Access decode; a claim only succeeds in PENDING with a live winner.
   always_comb begin
      wr_en      = req & bus_req.we;
      rd_en      = req & ~bus_req.we;
      claim_ok   = rd_en && (bus_req.addr == IRQ_CLAIM_ADDR) && (state_q == PENDING) && win_valid;
      cmp_wr     = wr_en && (bus_req.addr == IRQ_COMPLETE_ADDR)
                   && (bus_req.wdata == (IRQ_DATA_W'(claimed_q) + IRQ_DATA_W'(1)));
      completion = core_complete | cmp_wr;
   end

`ifdef LADYBIRD_IRQ_EDGE_EN
   logic [N_SRC-1:0] edge_q, sticky_q, prev_q, sticky_d, clr_mask;

   // Sticky capture of rising edges; clear on claim, a same-cycle edge wins.
   always_comb begin
      clr_mask = claim_ok ? (N_SRC'(1) << win_idx) : '0;
      sticky_d = ((sticky_q & ~clr_mask) | (src_pending & ~prev_q)) & edge_q;
      src_eff  = (edge_q & sticky_q) | (~edge_q & src_pending);
   end

   // Edge-mode state registers.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         edge_q   <= '0;
         sticky_q <= '0;
         prev_q   <= '0;
      end else begin
         prev_q   <= src_pending;
         sticky_q <= sticky_d;
         if (wr_en && (bus_req.addr == IRQ_EDGE_ADDR)) edge_q <= N_SRC'(bus_req.wdata);
      end
   end
`else
   // Level-sensitive sources only.
   always_comb src_eff = src_pending;
`endif

   // Per-source eligibility against enable and threshold.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         eligible[i] = src_eff[i] & enable_q[i] & (prio_q[i*PRIO_W +: PRIO_W] > thresh_q);
      end
   end

   ladybird_irq_arbiter #(
      .N_SRC  (N_SRC),
      .PRIO_W (PRIO_W)
   ) u_arbiter (
      .eligible (eligible),
      .prio     (prio_q),
      .valid    (win_valid),
      .idx      (win_idx)
   );

   // Next-state logic for the claim/complete handshake.
   always_comb begin
      state_d   = state_q;
      claimed_d = claimed_q;
      case (state_q)
         IDLE:    if (|eligible) state_d = PENDING;
         PENDING: begin
            if (claim_ok) begin
               state_d   = CLAIMED;
               claimed_d = win_idx;
            end else if (!(|eligible)) begin
               state_d = IDLE;
            end
         end
         CLAIMED: if (completion) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register and registered core/peripheral outputs.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q        <= IDLE;
         claimed_q      <= '0;
         irq_q          <= 1'b0;
         src_complete_q <= '0;
      end else begin
         state_q        <= state_d;
         claimed_q      <= claimed_d;
         irq_q          <= (state_d == PENDING);
         src_complete_q <= (state_d == DONE) ? (N_SRC'(1) << claimed_d) : '0;
      end
   end

   // Configuration register writes.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         enable_q <= '0;
         prio_q   <= '0;
         thresh_q <= '0;
      end else if (wr_en) begin
         case (bus_req.addr)
            IRQ_ENABLE_ADDR:    enable_q <= N_SRC'(bus_req.wdata);
            IRQ_PRIO_ADDR:      prio_q   <= PRIO_BITS'(bus_req.wdata);
            IRQ_THRESHOLD_ADDR: thresh_q <= PRIO_W'(bus_req.wdata);
            default: ;
         endcase
      end
   end

   // Read mux; unmapped addresses and unused high bits read zero.
   always_comb begin
      rd_val = '0;
      case (bus_req.addr)
         IRQ_ENABLE_ADDR:    rd_val = IRQ_DATA_W'(enable_q);
         IRQ_PRIO_ADDR:      rd_val = IRQ_DATA_W'(prio_q);
         IRQ_THRESHOLD_ADDR: rd_val = IRQ_DATA_W'(thresh_q);
         IRQ_CLAIM_ADDR:     rd_val = claim_ok ? (IRQ_DATA_W'(win_idx) + IRQ_DATA_W'(1)) : '0;
         IRQ_PENDING_ADDR:   rd_val = IRQ_DATA_W'(src_eff);
`ifdef LADYBIRD_IRQ_EDGE_EN
         IRQ_EDGE_ADDR:      rd_val = IRQ_DATA_W'(edge_q);
`endif
         default:            rd_val = '0;
      endcase
   end

   // Single-cycle acknowledge with registered read data.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= req;
         rdata_q <= rd_en ? rd_val : '0;
      end
   end

   assign irq          = irq_q;
   assign src_complete = src_complete_q;
   assign ack          = ack_q;
   assign rdata        = rdata_q;

endmodule

// File: tb/tb_ladybird_irq_controller.sv
// Scoreboard bench for ladybird_irq_controller: bus reads and completion pulses are
// queued at issue time and checked by a monitor branch when the DUT presents them.
module tb_ladybird_irq_controller;

   localparam int unsigned N_SRC  = 8;
   localparam int unsigned PRIO_W = 2;

   typedef struct {
      bit          chk;
      logic [31:0] val;
      string       nm;
   } bus_exp_t;

   logic              clk;
   logic              nrst;
   logic [N_SRC-1:0]  src_pending;
   logic [N_SRC-1:0]  src_complete;
   logic              irq;
   logic              core_complete;
   logic              req;
   logic              we;
   logic [3:0]        addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ack;

   logic              req_d;
   int                checks;
   int                failures;
   bus_exp_t          bus_q[$];
   logic [N_SRC-1:0]  pulse_q[$];

   ladybird_irq_controller #(
      .N_SRC  (N_SRC),
      .PRIO_W (PRIO_W)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .src_pending   (src_pending),
      .src_complete  (src_complete),
      .irq           (irq),
      .core_complete (core_complete),
      .req           (req),
      .we            (we),
      .addr          (addr),
      .wdata         (wdata),
      .rdata         (rdata),
      .ack           (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) req_d <= req;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input bit c, input logic [31:0] e, input string nm);
      bus_exp_t x;
      x.chk = c;
      x.val = e;
      x.nm  = nm;
      bus_q.push_back(x);
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      tick(1);
      req   = 1'b0;
      we    = 1'b0;
      wdata = '0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
      bus(1'b0, a, 32'h0, 1'b1, e, nm);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      bus(1'b1, a, d, 1'b0, 32'h0, "wr");
   endtask

   task automatic wait_irq(input string nm);
      int n;
      n = 0;
      while (!irq && n < 20) begin
         tick(1);
         n++;
      end
      chk(nm, 32'(irq), 32'd1);
   endtask

   task automatic pulse_core(input logic [N_SRC-1:0] exp_pulse);
      pulse_q.push_back(exp_pulse);
      core_complete = 1'b1;
      tick(1);
      core_complete = 1'b0;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      nrst          = 1'b0;
      src_pending   = '0;
      core_complete = 1'b0;
      req           = 1'b0;
      we            = 1'b0;
      addr          = '0;
      wdata         = '0;
      fork
         // Monitor: ack timing, read data and completion pulses.
         forever begin
            @(negedge clk);
            if (req_d === 1'b1 || ack === 1'b1) chk("ack_timing", 32'(ack), 32'(req_d));
            if (ack === 1'b1) begin
               if (bus_q.size() == 0) begin
                  chk("unexpected_ack", 32'd1, 32'd0);
               end else begin
                  bus_exp_t x;
                  x = bus_q.pop_front();
                  if (x.chk) chk(x.nm, rdata, x.val);
               end
            end
            if (src_complete !== '0) begin
               if (pulse_q.size() == 0) chk("unexpected_pulse", 32'(src_complete), 32'd0);
               else chk("src_complete", 32'(src_complete), 32'(pulse_q.pop_front()));
            end
         end
         begin
            // Reset state and register readback.
            tick(3);
            chk("rst_irq", 32'(irq), 32'd0);
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_src_complete", 32'(src_complete), 32'd0);
            nrst = 1'b1;
            tick(1);
            for (int a = 0; a < 6; a++) rd(4'(a), 32'h0, "rst_read");
            tick(1);
            chk("idle_irq", 32'(irq), 32'd0);

            // Priority winner, core completion, then lower-priority source.
            wr(4'h0, 32'hFF);
            wr(4'h1, 32'hC10);
            wr(4'h2, 32'h0);
            rd(4'h1, 32'hC10, "prio_readback");
            src_pending = 8'h24;
            tick(1);
            chk("irq_rise", 32'(irq), 32'd1);
            rd(4'h5, 32'h24, "pending_reg");
            rd(4'h3, 32'd6, "claim_src5");
            chk("irq_claimed", 32'(irq), 32'd0);
            src_pending = 8'h04;
            pulse_core(8'h20);
            wait_irq("irq_src2");
            rd(4'h3, 32'd3, "claim_src2");
            src_pending = 8'h00;
            pulse_core(8'h04);
            tick(3);

            // Equal priority tie, mismatched then matching COMPLETE write.
            wr(4'h1, 32'h208);
            src_pending = 8'h12;
            wait_irq("irq_tie");
            rd(4'h3, 32'd2, "claim_tie");
            wr(4'h4, 32'd5);
            tick(2);
            chk("mismatch_irq", 32'(irq), 32'd0);
            src_pending = 8'h00;
            pulse_q.push_back(8'h02);
            wr(4'h4, 32'd2);
            tick(3);

            // Threshold masks everything.
            wr(4'h2, 32'd3);
            src_pending = 8'hFF;
            tick(3);
            chk("thresh_irq", 32'(irq), 32'd0);
            rd(4'h3, 32'd0, "thresh_claim");
            tick(1);
            chk("thresh_irq_after", 32'(irq), 32'd0);
            src_pending = 8'h00;
            wr(4'h2, 32'd0);

            // Simultaneous core and register completion gives one pulse.
            wr(4'h1, 32'h40);
            src_pending = 8'h08;
            wait_irq("irq_src3");
            rd(4'h3, 32'd4, "claim_src3");
            pulse_q.push_back(8'h08);
            core_complete = 1'b1;
            wr(4'h4, 32'd4);
            core_complete = 1'b0;
            src_pending = 8'h00;
            tick(3);

            // Reset while claimed drops everything without a pulse.
            src_pending = 8'h08;
            wait_irq("irq_src3_again");
            rd(4'h3, 32'd4, "claim_src3_again");
            nrst = 1'b0;
            tick(1);
            nrst = 1'b1;
            chk("rst_mid_irq", 32'(irq), 32'd0);
            rd(4'h0, 32'd0, "rst_mid_enable");
            rd(4'h1, 32'd0, "rst_mid_prio");
            rd(4'h2, 32'd0, "rst_mid_thresh");
            tick(3);
            chk("rst_mid_irq_after", 32'(irq), 32'd0);
            src_pending = 8'h00;

`ifdef LADYBIRD_IRQ_EDGE_EN
            // Edge capture, clear on claim, re-latch on a claim-cycle edge.
            wr(4'h0, 32'h1);
            wr(4'h1, 32'h1);
            wr(4'h6, 32'h1);
            rd(4'h6, 32'h1, "edge_readback");
            src_pending = 8'h01;
            tick(1);
            src_pending = 8'h00;
            wait_irq("edge_irq");
            rd(4'h3, 32'd1, "edge_claim");
            rd(4'h5, 32'd0, "edge_sticky_clr");
            pulse_core(8'h01);
            tick(4);
            chk("edge_no_repend", 32'(irq), 32'd0);
            src_pending = 8'h01;
            tick(1);
            src_pending = 8'h00;
            wait_irq("edge_irq2");
            src_pending = 8'h01;
            rd(4'h3, 32'd1, "edge_claim2");
            rd(4'h5, 32'd1, "edge_relatch");
            pulse_core(8'h01);
            wait_irq("edge_repend");
            rd(4'h3, 32'd1, "edge_claim3");
            src_pending = 8'h00;
            pulse_core(8'h01);
            tick(3);
`else
            wr(4'h6, 32'h1);
            rd(4'h6, 32'h0, "edge_absent");
            tick(2);
`endif
         end
      join_any
      chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
      chk("pulse_q_drained", 32'(pulse_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
